// File: rtl/slot_pkg.sv
// Shared types for the slot machine credit path: FSM states and credit width.
// No logic; latency and backpressure are defined by the modules that use these types.
package slot_pkg;

    localparam int CW_DEF = 5;

    typedef logic [CW_DEF-1:0] credit_t;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT_LOW,
        GAP,
        FAULT
    } state_e;

endpackage

// File: rtl/payout_timer.sv
// Loadable down-counter with zero flag; a load takes effect on the next edge.
// Counts down one per cycle and holds at zero. It has no handshake and never stalls.
module payout_timer #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    output logic         zero_o
);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= load_val_i;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - W'(1);
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/coin_payout_dispenser.sv
// Pays the credit balance out one coin at a time over a req/ack handshake with the hopper.
// coin_req rises 1 cycle after the cashout edge; the hopper stalls payout by holding ack, bounded by a timeout.
module coin_payout_dispenser
    import slot_pkg::*;
#(
    parameter int CW             = CW_DEF,
    parameter int GAP_CYCLES     = 8,
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          load,
    input  logic [CW-1:0] credit_in,
    input  logic          cashout,
    input  logic          coin_ack,
    input  logic          fault_clr,
    output logic          coin_req,
    output logic [CW-1:0] balance,
    output logic          busy,
    output logic          done,
    output logic          fault
);

    localparam int TMAX = (TIMEOUT_CYCLES > GAP_CYCLES) ? TIMEOUT_CYCLES : GAP_CYCLES;
    localparam int TW   = (TMAX > 1) ? $clog2(TMAX + 1) : 1;
    localparam logic [TW-1:0] TO_LD  = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [TW-1:0] GAP_LD = (GAP_CYCLES > 0) ? TW'(GAP_CYCLES - 1) : '0;

    state_e        state_q;
    logic [CW-1:0] balance_q;
    logic          coin_req_q;
    logic          busy_q;
    logic          done_q;
    logic          fault_q;
    logic          cashout_q;

    logic          cashout_rise;
    logic          tmr_load;
    logic [TW-1:0] tmr_val;
    logic          tmr_zero;

    assign cashout_rise = cashout & ~cashout_q;

    // GAP and timeout never run together, so one timer serves both.
    // It is reloaded on every transition into REQ, WAIT_LOW or GAP.
    always_comb begin
        tmr_load = 1'b0;
        tmr_val  = TO_LD;
        case (state_q)
            IDLE:     tmr_load = !load && cashout_rise && (balance_q != '0);
            REQ:      tmr_load = coin_ack;
            WAIT_LOW: begin
                if (!coin_ack && (balance_q != '0)) begin
                    tmr_load = 1'b1;
                    tmr_val  = (GAP_CYCLES == 0) ? TO_LD : GAP_LD;
                end
            end
            GAP:      tmr_load = tmr_zero;
            default:  tmr_load = 1'b0;
        endcase
    end

    payout_timer #(.W(TW)) u_timer (
        .clk        (clk),
        .resetn     (resetn),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .zero_o     (tmr_zero)
    );

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q    <= IDLE;
            balance_q  <= '0;
            coin_req_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            fault_q    <= 1'b0;
            cashout_q  <= 1'b0;
        end else begin
            cashout_q <= cashout;
            done_q    <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (load) begin
                        balance_q <= credit_in;
                    end else if (cashout_rise) begin
                        if (balance_q != '0) begin
                            state_q    <= REQ;
                            coin_req_q <= 1'b1;
                            busy_q     <= 1'b1;
                        end else begin
                            done_q <= 1'b1;
                        end
                    end
                end
                REQ: begin
                    if (coin_ack) begin
                        if (balance_q != '0) begin
                            balance_q <= balance_q - CW'(1);
                        end
                        coin_req_q <= 1'b0;
                        state_q    <= WAIT_LOW;
                    end else if (tmr_zero) begin
                        coin_req_q <= 1'b0;
                        busy_q     <= 1'b0;
                        fault_q    <= 1'b1;
                        state_q    <= FAULT;
                    end
                end
                WAIT_LOW: begin
                    if (!coin_ack) begin
                        if (balance_q == '0) begin
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= IDLE;
                        end else if (GAP_CYCLES == 0) begin
                            coin_req_q <= 1'b1;
                            state_q    <= REQ;
                        end else begin
                            state_q <= GAP;
                        end
                    end else if (tmr_zero) begin
                        busy_q  <= 1'b0;
                        fault_q <= 1'b1;
                        state_q <= FAULT;
                    end
                end
                GAP: begin
                    if (tmr_zero) begin
                        coin_req_q <= 1'b1;
                        state_q    <= REQ;
                    end
                end
                FAULT: begin
                    if (fault_clr) begin
                        fault_q <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign coin_req = coin_req_q;
    assign balance  = balance_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign fault    = fault_q;

endmodule
